gpu_collision_builder: RTL and testbench

GPU_COLLISION_BUILDER -- requirements
Module: gpu_collision_builder

---
 rtl/gpu_collision_builder.sv | 216 +++++++++++++++++++++
 tb/tb_gpu_collision_builder.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_collision_builder.sv
// Collision bitmap builder: buffers batches of rects, then sweeps every X and Y coordinate
// and writes one bit per rect. Optional macro GPU_COLLISION_HIDE_EN masks rects of HIDE_COLOR.
module gpu_collision_builder #(
  parameter int          COORD_WIDTH = 10,
  parameter int          BATCH_RECTS = 16,
  parameter int          BATCHES     = 4,
  parameter int          X_MAX       = 640,
  parameter int          Y_MAX       = 480,
  parameter logic [15:0] HIDE_COLOR  = 16'h0000,
  localparam int         BITMAP_W    = BATCH_RECTS * BATCHES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [1:0]             mem_sel,
  output logic [COORD_WIDTH-1:0] mem_raddr,
  input  logic [BITMAP_W-1:0]    mem_rdata,
  output logic                   mem_we,
  output logic [COORD_WIDTH-1:0] mem_waddr,
  output logic [BITMAP_W-1:0]    mem_wdata,
  output logic                   busy,
  output logic                   finish
);

  localparam int RW = (BATCH_RECTS > 1) ? $clog2(BATCH_RECTS) : 1;
  localparam int BW = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam logic [COORD_WIDTH:0] X_END  = (COORD_WIDTH+1)'(X_MAX);
  localparam logic [COORD_WIDTH:0] Y_END  = (COORD_WIDTH+1)'(Y_MAX);
  localparam logic [COORD_WIDTH:0] X_LAST = (COORD_WIDTH+1)'(X_MAX + 1);
  localparam logic [COORD_WIDTH:0] Y_LAST = (COORD_WIDTH+1)'(Y_MAX + 1);
  localparam logic [RW-1:0] RECT_LAST  = RW'(BATCH_RECTS - 1);
  localparam logic [BW-1:0] BATCH_LAST = BW'(BATCHES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SWEEP_X, SWEEP_Y, DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             field_q, field_d;
  logic [RW-1:0]          rect_q, rect_d;
  logic [BW-1:0]          batch_q, batch_d;
  logic [COORD_WIDTH:0]   cnt_q, cnt_d;

  logic [COORD_WIDTH-1:0] left_q   [BATCH_RECTS];
  logic [COORD_WIDTH:0]   right_q  [BATCH_RECTS];
  logic [COORD_WIDTH-1:0] top_q    [BATCH_RECTS];
  logic [COORD_WIDTH:0]   bottom_q [BATCH_RECTS];
  logic [BATCH_RECTS-1:0] hide_q;

  logic                   vld_p1, vld_p2;
  logic [COORD_WIDTH-1:0] addr_p1, addr_p2;
  logic [BITMAP_W-1:0]    wdata_p2;

  logic                   accept, color_we, sweeping, issue_p0;
  logic [COORD_WIDTH:0]   sweep_end;
  logic [COORD_WIDTH-1:0] color_addr;
  logic [BATCH_RECTS-1:0] rect_bits;
  logic [BITMAP_W-1:0]    new_bits, base_bits;

  function automatic logic in_span(input logic [COORD_WIDTH:0] c,
                                   input logic [COORD_WIDTH:0] lo,
                                   input logic [COORD_WIDTH:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  assign accept     = (state_q == LOAD) && din_valid;
  assign color_we   = accept && (field_q == 3'd4);
  assign sweeping   = (state_q == SWEEP_X) || (state_q == SWEEP_Y);
  assign sweep_end  = (state_q == SWEEP_Y) ? Y_END : X_END;
  assign issue_p0   = sweeping && (cnt_q < sweep_end);
  assign color_addr = COORD_WIDTH'(int'(batch_q) * BATCH_RECTS + int'(rect_q));

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    rect_d  = rect_q;
    batch_d = batch_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        field_d = '0;
        rect_d  = '0;
        batch_d = '0;
      end
      LOAD: if (din_valid) begin
        if (field_q == 3'd4) begin
          field_d = '0;
          if (rect_q == RECT_LAST) begin
            rect_d  = '0;
            cnt_d   = '0;
            state_d = SWEEP_X;
          end else begin
            rect_d = rect_q + 1'b1;
          end
        end else begin
          field_d = field_q + 3'd1;
        end
      end
      SWEEP_X: if (cnt_q == X_LAST) begin
        cnt_d   = '0;
        state_d = SWEEP_Y;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      SWEEP_Y: if (cnt_q == Y_LAST) begin
        cnt_d = '0;
        if (batch_q == BATCH_LAST) begin
          batch_d = '0;
          state_d = DONE;
        end else begin
          batch_d = batch_q + 1'b1;
          state_d = LOAD;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      field_q <= '0;
      rect_q  <= '0;
      batch_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      rect_q  <= rect_d;
      batch_q <= batch_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rect capture: edges kept one bit wider so x+width never wraps
  always_ff @(posedge clk) begin
    if (accept) begin
      case (field_q)
        3'd0: left_q[rect_q]   <= din[COORD_WIDTH-1:0];
        3'd1: right_q[rect_q]  <= {1'b0, left_q[rect_q]} + {1'b0, din[COORD_WIDTH-1:0]};
        3'd2: top_q[rect_q]    <= din[COORD_WIDTH-1:0];
        3'd3: bottom_q[rect_q] <= {1'b0, top_q[rect_q]} + {1'b0, din[COORD_WIDTH-1:0]};
        default: ;
      endcase
    end
  end

`ifdef GPU_COLLISION_HIDE_EN
  always_ff @(posedge clk) begin
    if (color_we) hide_q[rect_q] <= (din == HIDE_COLOR);
  end
`else
  logic unused_hide_color;
  assign hide_q            = '0;
  assign unused_hide_color = ^HIDE_COLOR;
`endif

  // Stage p1: read data for addr_p1 is on mem_rdata; merge with this batch's span bits
  always_comb begin
    rect_bits = '0;
    for (int i = 0; i < BATCH_RECTS; i++) begin
      if (state_q == SWEEP_Y)
        rect_bits[i] = in_span({1'b0, addr_p1}, {1'b0, top_q[i]}, bottom_q[i]) & ~hide_q[i];
      else
        rect_bits[i] = in_span({1'b0, addr_p1}, {1'b0, left_q[i]}, right_q[i]) & ~hide_q[i];
    end
  end

  assign new_bits  = BITMAP_W'(rect_bits) << (int'(batch_q) * BATCH_RECTS);
  assign base_bits = (batch_q == '0) ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1  <= cnt_q[COORD_WIDTH-1:0];
    addr_p2  <= addr_p1;
    wdata_p2 <= base_bits | new_bits;
  end

  // Stage p2: bitmap write-back, two cycles after the read of the same address
  always_comb begin
    din_ready = (state_q == LOAD);
    busy      = (state_q != IDLE);
    finish    = (state_q == DONE);
    mem_sel   = 2'd0;
    if (state_q == LOAD)    mem_sel = 2'd2;
    if (state_q == SWEEP_Y) mem_sel = 2'd1;
    mem_raddr = issue_p0 ? cnt_q[COORD_WIDTH-1:0] : '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (color_we) begin
      mem_we    = 1'b1;
      mem_waddr = color_addr;
      mem_wdata = BITMAP_W'(din);
    end else if (sweeping && vld_p2) begin
      mem_we    = 1'b1;
      mem_waddr = addr_p2;
      mem_wdata = wdata_p2;
    end
  end

endmodule

// File: tb/tb_gpu_collision_builder.sv
// Bench for gpu_collision_builder: memory model plus a rect-span reference model of the bitmaps.
module tb_gpu_collision_builder;

  localparam int CW = 10, BR = 16, NB = 4, XM = 640, YM = 480, BW = BR * NB;
  localparam logic [15:0] HIDE = 16'h0000;
  localparam int EXP_CYC = 1 + NB * (5 * BR + XM + YM + 4);
  localparam int LIMIT   = 20000;
`ifdef GPU_COLLISION_HIDE_EN
  localparam bit HIDE_ON = 1'b1;
`else
  localparam bit HIDE_ON = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, din_valid = 1'b0;
  logic [15:0]   din = 16'h0;
  logic          din_ready, mem_we, busy, finish;
  logic [1:0]    mem_sel;
  logic [CW-1:0] mem_raddr, mem_waddr;
  logic [BW-1:0] mem_rdata, mem_wdata;

  logic [BW-1:0] xmem [0:1023];
  logic [BW-1:0] ymem [0:1023];
  logic [BW-1:0] cmem [0:1023];

  int rx [NB][BR];
  int rw [NB][BR];
  int ry [NB][BR];
  int rh [NB][BR];
  int rc [NB][BR];

  int checks = 0, failures = 0;

  gpu_collision_builder dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .mem_sel(mem_sel), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= (mem_sel == 2'd1) ? ymem[mem_raddr] : xmem[mem_raddr];
    if (mem_we) begin
      case (mem_sel)
        2'd0: xmem[mem_waddr] <= mem_wdata;
        2'd1: ymem[mem_waddr] <= mem_wdata;
        2'd2: cmem[mem_waddr] <= mem_wdata;
        default: ;
      endcase
    end
  end

  // Reference: bit b*BR+i is set where the rect covers coordinate c
  function automatic logic [BW-1:0] exp_map(input int axis, input int c);
    logic [BW-1:0] r;
    int lo, len;
    r = '0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < BR; i++) begin
        lo  = (axis == 0) ? (rx[b][i] & 1023) : (ry[b][i] & 1023);
        len = (axis == 0) ? (rw[b][i] & 1023) : (rh[b][i] & 1023);
        if (!(HIDE_ON && (rc[b][i] & 16'hFFFF) == int'(HIDE)) && c >= lo && c < lo + len)
          r[b*BR+i] = 1'b1;
      end
    return r;
  endfunction

  task automatic scan_maps(output int bad, output int where, output logic [BW-1:0] got,
                           output logic [BW-1:0] exp);
    logic [BW-1:0] e, g;
    bad = 0; where = -1; got = '0; exp = '0;
    for (int a = 0; a < 2; a++)
      for (int c = 0; c < ((a == 0) ? XM : YM); c++) begin
        e = exp_map(a, c);
        g = (a == 0) ? xmem[c] : ymem[c];
        if (g !== e) begin
          if (bad == 0) begin where = a * 10000 + c; got = g; exp = e; end
          bad++;
        end
      end
  endtask

  task automatic scan_colors(output int bad, output int where);
    bad = 0; where = -1;
    for (int k = 0; k < BW; k++)
      if (cmem[k] !== BW'(rc[k/BR][k%BR] & 16'hFFFF)) begin
        if (bad == 0) where = k;
        bad++;
      end
  endtask

  task automatic clear_rects();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < BR; i++) begin
        rx[b][i] = 0; rw[b][i] = 0; ry[b][i] = 0; rh[b][i] = 0; rc[b][i] = 0;
      end
  endtask

  task automatic rand_rects();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < BR; i++) begin
        rx[b][i] = $urandom_range(0, 700);
        rw[b][i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
        ry[b][i] = $urandom_range(0, 520);
        rh[b][i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
        rc[b][i] = $urandom_range(0, 65535);
      end
  endtask

  // One frame; abort_at>0 pulses reset (with start) at that cycle and returns
  task automatic run_frame(input bit toggle, input int abort_at, output int cycles,
                           output int fins, output bit timeout);
    int words [NB*BR*5];
    int idx, n;
    bit vld, rdy;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < BR; i++) begin
        words[(b*BR+i)*5+0] = rx[b][i];
        words[(b*BR+i)*5+1] = rw[b][i];
        words[(b*BR+i)*5+2] = ry[b][i];
        words[(b*BR+i)*5+3] = rh[b][i];
        words[(b*BR+i)*5+4] = rc[b][i];
      end
    cycles = 0; fins = 0; timeout = 1'b0; idx = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (1) begin
      if (abort_at != 0 && n == abort_at) begin
        din_valid = 1'b0; reset = 1'b1; start = 1'b1;
        @(negedge clk); reset = 1'b0; start = 1'b0;
        return;
      end
      if (finish) begin fins++; if (cycles == 0) cycles = n; end
      if (cycles != 0 && n >= cycles + 4) break;
      if (n >= LIMIT) begin timeout = 1'b1; break; end
      vld = (idx < NB*BR*5) && (!toggle || (n % 2 == 0));
      din_valid = vld;
      din = 16'h0;
      if (vld) din = 16'(words[idx]);
      rdy = din_ready;
      @(negedge clk);
      if (vld && rdy) idx++;
      n++;
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, finish, din_ready, mem_we, mem_sel} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, finish, din_ready, mem_we, mem_sel});
    end
    checks++;
    if ({mem_raddr, mem_waddr} !== '0) begin
      failures++;
      $display("FAIL reset_addr got raddr=%0d waddr=%0d exp=0", mem_raddr, mem_waddr);
    end
    checks++;
    if (mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_wdata got=%h exp=0", mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, din_ready} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=00", {busy, din_ready});
    end
  endtask

  task automatic test_basic();
    int cyc, fins, bad, where;
    bit to;
    logic [BW-1:0] g, e;
    clear_rects();
    rx[0][0] = 10; rw[0][0] = 5; ry[0][0] = 20; rh[0][0] = 2; rc[0][0] = 16'h1234;
    run_frame(1'b0, 0, cyc, fins, to);
    checks++;
    if (to !== 1'b0 || fins !== 1) begin
      failures++;
      $display("FAIL basic_finish got timeout=%0d pulses=%0d exp timeout=0 pulses=1", to, fins);
    end
    checks++;
    if (cyc !== EXP_CYC) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", cyc, EXP_CYC);
    end
    checks++;
    if ({xmem[15][0], xmem[14][0], xmem[13][0], xmem[12][0], xmem[11][0], xmem[10][0]} !== 6'b011111) begin
      failures++;
      $display("FAIL basic_xbits got=%b exp=011111",
               {xmem[15][0], xmem[14][0], xmem[13][0], xmem[12][0], xmem[11][0], xmem[10][0]});
    end
    checks++;
    if ({ymem[22][0], ymem[21][0], ymem[20][0], ymem[19][0]} !== 4'b0110) begin
      failures++;
      $display("FAIL basic_ybits got=%b exp=0110", {ymem[22][0], ymem[21][0], ymem[20][0], ymem[19][0]});
    end
    checks++;
    if (cmem[0] !== BW'(16'h1234)) begin
      failures++;
      $display("FAIL basic_color0 got=%h exp=1234", cmem[0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after got=%b exp=0", busy);
    end
    scan_maps(bad, where, g, e);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL basic_maps at=%0d got=%h exp=%h bad=%0d", where, g, e, bad);
    end
  endtask

  task automatic test_two_frames();
    int cyc, fins, bad, where;
    bit to;
    logic [BW-1:0] g, e;
    clear_rects();
    rx[0][0] = 10; rw[0][0] = 5; ry[0][0] = 20; rh[0][0] = 2; rc[0][0] = 16'h1234;
    run_frame(1'b0, 0, cyc, fins, to);
    rx[0][0] = 100;
    run_frame(1'b0, 0, cyc, fins, to);
    checks++;
    if (to !== 1'b0 || fins !== 1) begin
      failures++;
      $display("FAIL frame2_finish got timeout=%0d pulses=%0d exp timeout=0 pulses=1", to, fins);
    end
    checks++;
    if (xmem[10] !== '0) begin
      failures++;
      $display("FAIL frame2_clear10 got=%h exp=0", xmem[10]);
    end
    checks++;
    if (xmem[100][0] !== 1'b1) begin
      failures++;
      $display("FAIL frame2_x100 got=%b exp=1", xmem[100][0]);
    end
    scan_maps(bad, where, g, e);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL frame2_maps at=%0d got=%h exp=%h bad=%0d", where, g, e, bad);
    end
  endtask

  task automatic test_or_batch();
    int cyc, fins, bad, where, miss;
    bit to;
    logic [BW-1:0] g, e;
    rand_rects();
    rx[2][3] = 0; rw[2][3] = 640; rc[2][3] = 16'h5555;
    run_frame(1'b0, 0, cyc, fins, to);
    miss = 0;
    for (int c = 0; c < XM; c++) if (xmem[c][35] !== 1'b1) miss++;
    checks++;
    if (miss !== 0) begin
      failures++;
      $display("FAIL or_bit35 got %0d addresses clear exp=0", miss);
    end
    scan_maps(bad, where, g, e);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL or_maps at=%0d got=%h exp=%h bad=%0d", where, g, e, bad);
    end
    scan_colors(bad, where);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL or_colors first=%0d got=%h bad=%0d exp=0", where, cmem[where < 0 ? 0 : where], bad);
    end
  endtask

  task automatic test_nowrap();
    int cyc, fins, bad, where, hits, wide;
    bit to;
    logic [BW-1:0] g, e;
    rand_rects();
    rx[1][5] = 1023; rw[1][5] = 1023; rc[1][5] = 16'h0101;
    rx[3][7] = 600;  rw[3][7] = 1000; ry[3][7] = 400; rh[3][7] = 1000; rc[3][7] = 16'h0202;
    run_frame(1'b0, 0, cyc, fins, to);
    hits = 0;
    for (int c = 0; c < XM; c++) if (xmem[c][21] !== 1'b0) hits++;
    checks++;
    if (hits !== 0) begin
      failures++;
      $display("FAIL nowrap_far got %0d addresses set exp=0", hits);
    end
    wide = 0;
    for (int c = 600; c < XM; c++) if (xmem[c][55] === 1'b1) wide++;
    for (int c = 400; c < YM; c++) if (ymem[c][55] === 1'b1) wide++;
    checks++;
    if (wide !== 120) begin
      failures++;
      $display("FAIL nowrap_wide got=%0d set exp=120", wide);
    end
    scan_maps(bad, where, g, e);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL nowrap_maps at=%0d got=%h exp=%h bad=%0d", where, g, e, bad);
    end
  endtask

  task automatic test_toggle_abort();
    int cyc, fins, bad, where;
    bit to;
    logic [BW-1:0] g, e;
    rand_rects();
    run_frame(1'b1, 0, cyc, fins, to);
    checks++;
    if (to !== 1'b0 || fins !== 1) begin
      failures++;
      $display("FAIL toggle_finish got timeout=%0d pulses=%0d exp timeout=0 pulses=1", to, fins);
    end
    scan_maps(bad, where, g, e);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL toggle_maps at=%0d got=%h exp=%h bad=%0d", where, g, e, bad);
    end
    run_frame(1'b0, 900, cyc, fins, to);
    checks++;
    if ({busy, mem_we, finish} !== 3'b000) begin
      failures++;
      $display("FAIL abort_next got busy/we/finish=%b exp=000", {busy, mem_we, finish});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mem_we} !== 2'b00) begin
      failures++;
      $display("FAIL abort_start_ignored got busy/we=%b exp=00", {busy, mem_we});
    end
  endtask

  task automatic test_random();
    int cyc, fins, bad, where;
    bit to;
    logic [BW-1:0] g, e;
    for (int f = 0; f < 2; f++) begin
      rand_rects();
      run_frame(1'b0, 0, cyc, fins, to);
      checks++;
      if (cyc !== EXP_CYC || fins !== 1) begin
        failures++;
        $display("FAIL rand%0d_frame got cycles=%0d pulses=%0d exp cycles=%0d pulses=1", f, cyc, fins, EXP_CYC);
      end
      scan_maps(bad, where, g, e);
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rand%0d_maps at=%0d got=%h exp=%h bad=%0d", f, where, g, e, bad);
      end
      scan_colors(bad, where);
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rand%0d_colors first=%0d bad=%0d exp=0", f, where, bad);
      end
    end
  endtask

  task automatic test_hide();
    int cyc, fins, bad, where;
    bit to;
    logic [BW-1:0] g, e;
    logic exp_bit;
    clear_rects();
    rx[0][0] = 10; rw[0][0] = 5; ry[0][0] = 20; rh[0][0] = 2; rc[0][0] = int'(HIDE);
    rc[0][1] = 16'hBEEF;
    run_frame(1'b0, 0, cyc, fins, to);
    exp_bit = !HIDE_ON;
    checks++;
    if ({xmem[12][0], ymem[21][0]} !== {exp_bit, exp_bit}) begin
      failures++;
      $display("FAIL hide_bits got=%b exp=%b", {xmem[12][0], ymem[21][0]}, {exp_bit, exp_bit});
    end
    checks++;
    if (cmem[0] !== BW'(HIDE) || cmem[1] !== BW'(16'hBEEF)) begin
      failures++;
      $display("FAIL hide_color got=%h,%h exp=%h,beef", cmem[0], cmem[1], HIDE);
    end
    scan_maps(bad, where, g, e);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hide_maps at=%0d got=%h exp=%h bad=%0d", where, g, e, bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_two_frames();
    test_or_batch();
    test_nowrap();
    test_toggle_abort();
    test_random();
    test_hide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
